// File: rtl/gpio_regfile_pkg.sv
// Shared constants for the GPIO register file: word addresses, edge-mode encodings,
// identification defaults and the byte-lane mask helper.
package gpio_regfile_pkg;

    localparam logic [2:0] ADDR_CNAME      = 3'd0;
    localparam logic [2:0] ADDR_CVERSION   = 3'd1;
    localparam logic [2:0] ADDR_TRISTATE   = 3'd2;
    localparam logic [2:0] ADDR_DATA       = 3'd3;
    localparam logic [2:0] ADDR_PINSTATE   = 3'd4;
    localparam logic [2:0] ADDR_IRQ_MASK   = 3'd5;
    localparam logic [2:0] ADDR_IRQ_STATUS = 3'd6;
    localparam logic [2:0] ADDR_SCRATCH    = 3'd7;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_BOTH = 2;

    localparam logic [31:0] CNAME_DEFAULT    = 32'h48524a44;
    localparam logic [31:0] CVERSION_DEFAULT = 32'h00000002;

    function automatic logic [31:0] byte_mask(input logic [3:0] wben);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{wben[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/gpio_regfile_if.sv
// Peripheral register bus between the core (master) and the GPIO register file (slave).
interface gpio_regfile_if;

    logic        req;
    logic        r_wn;
    logic [2:0]  addr;
    logic [3:0]  wben;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (
        output req,
        output r_wn,
        output addr,
        output wben,
        output wdata,
        input  rdata,
        input  rvalid
    );

    modport slave (
        input  req,
        input  r_wn,
        input  addr,
        input  wben,
        input  wdata,
        output rdata,
        output rvalid
    );

endinterface

// File: rtl/gpio_sync_edge.sv
// Pad synchroniser chain plus per-pin edge detector with selectable edge polarity.
module gpio_sync_edge
    import gpio_regfile_pkg::*;
#(
    parameter int unsigned NUM_PINS    = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = EDGE_RISE
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_PINS-1:0] pin_in,
    output logic [NUM_PINS-1:0] pin_sync,
    output logic [NUM_PINS-1:0] edge_pulse
);

    logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q;
    logic [SYNC_STAGES-1:0]               fill_q;
    logic [NUM_PINS-1:0]                  pin_prev_q;
    logic                                 primed_q;
    logic [NUM_PINS-1:0]                  rising;
    logic [NUM_PINS-1:0]                  falling;
    logic [NUM_PINS-1:0]                  edge_sel;

    // fill_q tracks how far real pad samples have travelled down the chain, so primed
    // only asserts once pin_prev holds a sampled value rather than the reset zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            fill_q     <= '0;
            pin_prev_q <= '0;
            primed_q   <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pin_in};
            fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            pin_prev_q <= sync_q[SYNC_STAGES-1];
            primed_q   <= fill_q[SYNC_STAGES-1];
        end
    end

    assign pin_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        rising  = pin_sync & ~pin_prev_q;
        falling = ~pin_sync & pin_prev_q;
        case (EDGE_MODE)
            EDGE_FALL: edge_sel = falling;
            EDGE_BOTH: edge_sel = rising | falling;
            default:   edge_sel = rising;
        endcase
        edge_pulse = primed_q ? edge_sel : '0;
    end

endmodule

// File: rtl/gpio_regfile.sv
// GPIO control/status register file: ID, direction, output data, pin state, W1C edge
// status with mask, scratch, and a registered interrupt line.
module gpio_regfile
    import gpio_regfile_pkg::*;
#(
    parameter int unsigned NUM_PINS    = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = EDGE_RISE,
    parameter logic [31:0] CNAME       = CNAME_DEFAULT,
    parameter logic [31:0] CVERSION    = CVERSION_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    gpio_regfile_if.slave       bus,
    input  logic [NUM_PINS-1:0] pin_in,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                irq
);

    logic [NUM_PINS-1:0] pin_sync;
    logic [NUM_PINS-1:0] edge_pulse;

    logic [NUM_PINS-1:0] tristate_q, tristate_d;
    logic [NUM_PINS-1:0] data_q, data_d;
    logic [NUM_PINS-1:0] mask_q, mask_d;
    logic [NUM_PINS-1:0] status_q, status_d;
    logic [31:0]         scratch_q, scratch_d;
    logic                irq_q;

    logic                rd_pend_q;
    logic [2:0]          rd_addr_q;
    logic [31:0]         rdata_q;
    logic                rvalid_q;
    logic [31:0]         rd_word;

    logic                wr_en;
    logic [31:0]         bmask;
    logic [NUM_PINS-1:0] pmask;
    logic [NUM_PINS-1:0] wdata_p;
    logic [NUM_PINS-1:0] status_clr;

    gpio_sync_edge #(
        .NUM_PINS    (NUM_PINS),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
    ) u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .pin_in     (pin_in),
        .pin_sync   (pin_sync),
        .edge_pulse (edge_pulse)
    );

    assign wr_en   = bus.req & ~bus.r_wn;
    assign bmask   = byte_mask(bus.wben);
    assign pmask   = bmask[NUM_PINS-1:0];
    assign wdata_p = bus.wdata[NUM_PINS-1:0];

    always_comb begin
        tristate_d = tristate_q;
        data_d     = data_q;
        mask_d     = mask_q;
        scratch_d  = scratch_q;
        status_clr = '0;
        if (wr_en) begin
            case (bus.addr)
                ADDR_TRISTATE:   tristate_d = (tristate_q & ~pmask) | (wdata_p & pmask);
                ADDR_DATA:       data_d     = (data_q & ~pmask) | (wdata_p & pmask);
                ADDR_IRQ_MASK:   mask_d     = (mask_q & ~pmask) | (wdata_p & pmask);
                ADDR_IRQ_STATUS: status_clr = wdata_p & pmask;
                ADDR_SCRATCH:    scratch_d  = (scratch_q & ~bmask) | (bus.wdata & bmask);
                default:         ;
            endcase
        end
        // A new edge overrides a simultaneous W1C on the same bit.
        status_d = (status_q & ~status_clr) | edge_pulse;
    end

    always_comb begin
        rd_word = '0;
        case (rd_addr_q)
            ADDR_CNAME:      rd_word = CNAME;
            ADDR_CVERSION:   rd_word = CVERSION;
            ADDR_TRISTATE:   rd_word[NUM_PINS-1:0] = tristate_q;
            ADDR_DATA:       rd_word[NUM_PINS-1:0] = data_q;
            ADDR_PINSTATE:   rd_word[NUM_PINS-1:0] = pin_sync;
            ADDR_IRQ_MASK:   rd_word[NUM_PINS-1:0] = mask_q;
            ADDR_IRQ_STATUS: rd_word[NUM_PINS-1:0] = status_q;
            default:         rd_word = scratch_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tristate_q <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            status_q   <= '0;
            scratch_q  <= '0;
            irq_q      <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_addr_q  <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            tristate_q <= tristate_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            status_q   <= status_d;
            scratch_q  <= scratch_d;
            irq_q      <= |(status_q & mask_q);
            rd_pend_q  <= bus.req & bus.r_wn;
            if (bus.req && bus.r_wn) begin
                rd_addr_q <= bus.addr;
            end
            rvalid_q <= rd_pend_q;
            if (rd_pend_q) begin
                rdata_q <= rd_word;
            end
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign gpio_out   = data_q;
    assign gpio_oe    = tristate_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_regfile.sv
// Directed bench for gpio_regfile: register map, byte lanes, edge status/W1C, irq timing,
// back-to-back access and reset during a pending read.
module tb_gpio_regfile;
    import gpio_regfile_pkg::*;

    localparam int unsigned NP = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NP-1:0] pin_in;
    logic [NP-1:0] gpio_out;
    logic [NP-1:0] gpio_oe;
    logic          irq;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_regfile_if bus ();

    gpio_regfile #(
        .NUM_PINS    (NP),
        .SYNC_STAGES (2),
        .EDGE_MODE   (EDGE_RISE)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .pin_in   (pin_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
        @(negedge clk);
        bus.req  = 1'b1;
        bus.r_wn = 1'b1;
        bus.addr = a;
        @(negedge clk);
        bus.req = 1'b0;
        check({tag, "_rv_early"}, 32'(bus.rvalid), 32'd0);
        @(negedge clk);
        check({tag, "_rv"}, 32'(bus.rvalid), 32'd1);
        check(tag, bus.rdata, exp);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk);
        bus.req   = 1'b1;
        bus.r_wn  = 1'b0;
        bus.addr  = a;
        bus.wben  = be;
        bus.wdata = d;
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        bus.req   = 1'b0;
        bus.r_wn  = 1'b1;
        bus.addr  = '0;
        bus.wben  = '0;
        bus.wdata = '0;
        pin_in    = 16'hFFFF;

        // Reset values, with pins held high through reset release.
        idle(2);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_oe", 32'(gpio_oe), 32'd0);
        check("rst_out", 32'(gpio_out), 32'd0);
        reset_n = 1'b1;
        idle(6);

        bus_read("rd_cname", ADDR_CNAME, 32'h48524a44);
        bus_read("rd_cver", ADDR_CVERSION, 32'h00000002);
        bus_read("rd_tri", ADDR_TRISTATE, 32'd0);
        bus_read("rd_data", ADDR_DATA, 32'd0);
        bus_read("rd_pins", ADDR_PINSTATE, 32'h0000FFFF);
        bus_read("rd_mask", ADDR_IRQ_MASK, 32'd0);
        bus_read("rd_stat_primed", ADDR_IRQ_STATUS, 32'd0);
        bus_read("rd_scratch", ADDR_SCRATCH, 32'd0);
        check("irq_primed", 32'(irq), 32'd0);

        // Byte-lane writes to a pin-sized register.
        bus_write(ADDR_TRISTATE, 4'b0001, 32'hFFFF_A5C3);
        check("oe_lane0", 32'(gpio_oe), 32'h0000_00C3);
        bus_read("rd_tri_l0", ADDR_TRISTATE, 32'h0000_00C3);
        bus_write(ADDR_TRISTATE, 4'b0010, 32'hFFFF_A5C3);
        bus_read("rd_tri_l1", ADDR_TRISTATE, 32'h0000_A5C3);
        bus_write(ADDR_TRISTATE, 4'b1100, 32'hFFFF_FFFF);
        bus_read("rd_tri_hi", ADDR_TRISTATE, 32'h0000_A5C3);
        bus_write(ADDR_DATA, 4'b1111, 32'h1234_5678);
        check("out_data", 32'(gpio_out), 32'h0000_5678);
        check("wr_no_rvalid", 32'(bus.rvalid), 32'd0);
        bus_write(ADDR_CNAME, 4'b1111, 32'h0);
        bus_read("rd_cname_ro", ADDR_CNAME, 32'h48524a44);

        // Falling edges do not set status in rising mode.
        pin_in = 16'h0000;
        idle(5);
        bus_read("rd_stat_fall", ADDR_IRQ_STATUS, 32'd0);
        bus_write(ADDR_IRQ_MASK, 4'b1111, 32'h0000_0001);
        bus_read("rd_mask1", ADDR_IRQ_MASK, 32'h0000_0001);

        // Rising edge on pin 0: status at edge 3, irq at edge 4.
        @(negedge clk);
        pin_in = 16'h0001;
        idle(3);
        check("irq_pre", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_set", 32'(irq), 32'd1);
        bus_read("rd_stat0", ADDR_IRQ_STATUS, 32'h0000_0001);
        bus_write(ADDR_IRQ_STATUS, 4'b0001, 32'h0000_0001);
        check("irq_hold", 32'(irq), 32'd1);
        @(negedge clk);
        check("irq_clr", 32'(irq), 32'd0);
        bus_read("rd_stat0_clr", ADDR_IRQ_STATUS, 32'd0);

        // Unmasked edge sets status without irq; lane gating of W1C; mask raises irq.
        pin_in = 16'h0003;
        idle(5);
        check("irq_unmasked", 32'(irq), 32'd0);
        bus_read("rd_stat1", ADDR_IRQ_STATUS, 32'h0000_0002);
        bus_write(ADDR_IRQ_STATUS, 4'b0000, 32'hFFFF_FFFF);
        bus_read("rd_stat1_nolane", ADDR_IRQ_STATUS, 32'h0000_0002);
        bus_write(ADDR_IRQ_MASK, 4'b0001, 32'h0000_0003);
        @(negedge clk);
        check("irq_mask_on", 32'(irq), 32'd1);
        bus_write(ADDR_IRQ_STATUS, 4'b0001, 32'h0000_0002);
        bus_read("rd_stat1_clr", ADDR_IRQ_STATUS, 32'd0);
        check("irq_mask_off", 32'(irq), 32'd0);

        // Set wins over a simultaneous W1C on bit 3; bit 2 still clears.
        pin_in = 16'h0007;
        idle(5);
        bus_read("rd_stat2", ADDR_IRQ_STATUS, 32'h0000_0004);
        @(negedge clk);
        pin_in = 16'h000F;
        idle(2);
        bus.req   = 1'b1;
        bus.r_wn  = 1'b0;
        bus.addr  = ADDR_IRQ_STATUS;
        bus.wben  = 4'b0001;
        bus.wdata = 32'h0000_000C;
        @(negedge clk);
        bus.req = 1'b0;
        bus_read("rd_stat_collide", ADDR_IRQ_STATUS, 32'h0000_0008);

        // Back-to-back write then read of SCRATCH.
        @(negedge clk);
        bus.req   = 1'b1;
        bus.r_wn  = 1'b0;
        bus.addr  = ADDR_SCRATCH;
        bus.wben  = 4'b1111;
        bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.r_wn = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        check("b2b_rvalid", 32'(bus.rvalid), 32'd1);
        check("b2b_rdata", bus.rdata, 32'hDEAD_BEEF);
        bus_write(ADDR_SCRATCH, 4'b1000, 32'h1122_3344);
        bus_read("rd_scratch_l3", ADDR_SCRATCH, 32'h11AD_BEEF);

        // Reset asserted while a read is pending.
        @(negedge clk);
        bus.req  = 1'b1;
        bus.r_wn = 1'b1;
        bus.addr = ADDR_SCRATCH;
        @(negedge clk);
        bus.req = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("rstmid_rvalid0", 32'(bus.rvalid), 32'd0);
        check("rstmid_rdata", bus.rdata, 32'd0);
        @(negedge clk);
        check("rstmid_rvalid1", 32'(bus.rvalid), 32'd0);
        check("rstmid_oe", 32'(gpio_oe), 32'd0);
        idle(5);
        check("rstmid_irq", 32'(irq), 32'd0);
        bus_read("rd_stat_rst", ADDR_IRQ_STATUS, 32'd0);
        bus_read("rd_scratch_rst", ADDR_SCRATCH, 32'd0);
        bus_read("rd_pins_rst", ADDR_PINSTATE, 32'h0000_000F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
